riscv_test_monitor: RTL and testbench
=====================================

Name: riscv_test_monitor

Overview:
- Synthesizable pass/fail/timeout/hang monitor that sits directly downstream of the Core.
- Consumes the Core's retirement stream and x3 (gp) value, and decides the riscv-tests outcome in hardware.
- Exposes a sticky, registered status so benches and FPGA builds share one verdict source instead of ad-hoc pc polling.

Parameters:
- HALT_PC, 32'h0000_0044: retire address of the test-end ecall (write_tohost) instruction.
- TIMEOUT_CYCLES, 5000: cycles allowed in RUN before TIMEOUT.
- HANG_LIMIT, 16: consecutive retires at the same non-HALT pc that declare HANG; must be ≥2.
- CNT_W, 32: width of the cycle and retire counters.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- retire_valid  input  1  one instruction retired this cycle
- retire_pc  input  32  pc of the retired instruction, valid when retire_valid=1
- gp_value  input  32  current x3 (core.rs[3]), sampled on the halting retire
- done  output  1  verdict reached; sticky until rst
- passed  output  1  gp==1 at halt
- failed  output  1  halt with gp!=1
- timed_out  output  1  TIMEOUT_CYCLES elapsed without halt
- hung  output  1  pc repeated HANG_LIMIT retires without halt
- fail_testnum  output  31  gp[31:1] captured at a failing halt, else 0
- status  output  3  encoded state (see package)
- cycle_count  output  CNT_W  cycles spent in RUN
- retire_count  output  CNT_W  retires counted in RUN

Behaviour:
- Reset (rst=1 at posedge): state=RUN, all outputs 0, counters 0, hang tracker cleared. This applies mid-operation too; verdicts clear the next cycle.
- States: RUN, PASS, FAIL, TIMEOUT, HANG. All except RUN are terminal and hold until rst.
- RUN, every cycle:
  - cycle_count += 1.
  - retire_count += 1 when retire_valid=1.
  - Counters saturate at all-ones and freeze in terminal states.
- Halt detection: retire_valid=1 and retire_pc==HALT_PC. Next state is decided from gp_value in the same cycle:
  - gp_value==1 → PASS.
  - gp_value[0]==1, gp_value!=1 → FAIL, fail_testnum=gp_value[31:1].
  - gp_value[0]==0 → FAIL, fail_testnum=0 (malformed code).
- Timeout: in RUN, when cycle_count would become TIMEOUT_CYCLES → TIMEOUT; cycle_count holds TIMEOUT_CYCLES.
- Hang: in RUN, a retire at the same pc as the previous retire increments the repeat count; any other pc reloads it to 1. Reaching HANG_LIMIT at a pc != HALT_PC → HANG.
- Priority in the same cycle: halt > hang > timeout.
- Latency: all outputs are registered. done, the verdict flag and status assert on the cycle after the deciding event.
- Exactly one of passed/failed/timed_out/hung is 1 whenever done=1; all are 0 when done=0.
- retire_valid=0 cycles do not affect the hang tracker.
- retire_pc/gp_value are ignored when retire_valid=0.

Decomposition:
- Package riscv_test_monitor_pkg holds:
  - state/status encoding: RUN=0, PASS=1, FAIL=2, TIMEOUT=3, HANG=4
  - default HALT_PC constant
  - PASS_GP=32'h1 constant
- Sub-module pc_hang_detector: registered last_pc, repeat counter sized to HANG_LIMIT, and a hang_hit output. It has its own clear input driven by rst or a terminal state.
- The top holds the FSM, counters and verdict capture.

Test Plan:
- Pass: 10 retires at distinct pcs, then retire pc=0x44 with gp=1 → next cycle done=1, passed=1, status=1, retire_count=11.
- Fail: retire pc=0x44 with gp=32'h7 → failed=1, fail_testnum=3, status=2. Then 100 more retires → outputs and counters unchanged.
- Timeout (TIMEOUT_CYCLES=50): retires never hit 0x44 and pcs vary → timed_out=1 on the cycle after cycle_count reaches 50, cycle_count=50.
- Hang (HANG_LIMIT=4): retire pc=0x100 four times consecutively → hung=1. Variant 0x100,0x100,0x104,0x100 → no hang.
- Priority: the halting retire with gp=1 lands on the cycle the timeout would fire → passed=1, timed_out=0.
- Reset mid-run/after verdict: assert rst for one cycle after PASS → next cycle done=0, counters 0, status=0; a new run then reaches FAIL correctly.

Source files
------------

// File: rtl/riscv_test_monitor_pkg.sv
// riscv_test_monitor_pkg: verdict encoding and constants shared by the test monitor
package riscv_test_monitor_pkg;
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    PASS    = 3'd1,
    FAIL    = 3'd2,
    TIMEOUT = 3'd3,
    HANG    = 3'd4
  } state_t;
  localparam logic [31:0] DEFAULT_HALT_PC = 32'h0000_0044;
  localparam logic [31:0] PASS_GP = 32'h0000_0001;
endpackage

// File: rtl/riscv_test_monitor_hang.sv
// pc_hang_detector: flags the retire that makes the same pc repeat HANG_LIMIT times in a row
module pc_hang_detector #(
  parameter int HANG_LIMIT = 16
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        retire_valid,
  input  logic [31:0] retire_pc,
  output logic        hang_hit
);
  localparam int CW = $clog2(HANG_LIMIT + 1);
  logic [31:0]   last_pc;
  logic [CW-1:0] repeat_count;
  logic          same;
  // repeat_count==0 marks "no retire seen yet", so the first retire never matches
  assign same = repeat_count != '0 && retire_pc == last_pc;
  assign hang_hit = retire_valid && same && repeat_count >= CW'(HANG_LIMIT - 1);
  always_ff @(posedge clk)
    if (clear) begin
      last_pc <= '0;
      repeat_count <= '0;
    end else if (retire_valid) begin
      last_pc <= retire_pc;
      repeat_count <= !same ? CW'(1) : repeat_count == CW'(HANG_LIMIT) ? repeat_count : repeat_count + CW'(1);
    end
endmodule

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: decides pass/fail/timeout/hang of a riscv-test from the retire stream
module riscv_test_monitor
  import riscv_test_monitor_pkg::*;
#(
  parameter logic [31:0] HALT_PC        = DEFAULT_HALT_PC,
  parameter int          TIMEOUT_CYCLES = 5000,
  parameter int          HANG_LIMIT     = 16,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_valid,
  input  logic [31:0]      retire_pc,
  input  logic [31:0]      gp_value,
  output logic             done,
  output logic             passed,
  output logic             failed,
  output logic             timed_out,
  output logic             hung,
  output logic [30:0]      fail_testnum,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);
  state_t           state;
  logic             halt, hang_hit, timeout_hit;
  logic [CNT_W-1:0] cyc_next, ret_next;
  assign halt = retire_valid && retire_pc == HALT_PC;
  assign cyc_next = &cycle_count ? cycle_count : cycle_count + CNT_W'(1);
  assign ret_next = &retire_count ? retire_count : retire_count + CNT_W'(1);
  assign timeout_hit = cyc_next == CNT_W'(TIMEOUT_CYCLES);
  assign status = state;
  pc_hang_detector #(.HANG_LIMIT(HANG_LIMIT)) u_hang (
    .clk(clk),
    .clear(rst || state != RUN),
    .retire_valid(retire_valid),
    .retire_pc(retire_pc),
    .hang_hit(hang_hit)
  );
  // Verdict priority within one cycle: halt, then hang, then timeout
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      done <= 1'b0;
      passed <= 1'b0;
      failed <= 1'b0;
      timed_out <= 1'b0;
      hung <= 1'b0;
      fail_testnum <= '0;
      cycle_count <= '0;
      retire_count <= '0;
    end else if (state == RUN) begin
      cycle_count <= cyc_next;
      if (retire_valid) retire_count <= ret_next;
      if (halt) begin
        done <= 1'b1;
        if (gp_value == PASS_GP) begin
          state <= PASS;
          passed <= 1'b1;
        end else begin
          state <= FAIL;
          failed <= 1'b1;
          fail_testnum <= gp_value[0] ? gp_value[31:1] : '0;
        end
      end else if (hang_hit) begin
        state <= HANG;
        done <= 1'b1;
        hung <= 1'b1;
      end else if (timeout_hit) begin
        state <= TIMEOUT;
        done <= 1'b1;
        timed_out <= 1'b1;
      end
    end
endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: directed plan scenarios plus randomized runs against a sequence-scan model
module tb_riscv_test_monitor;
  localparam logic [31:0] HALT = 32'h44;
  localparam int TO = 50;
  localparam int HL = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic [31:0] gp_value = '0;
  logic done, passed, failed, timed_out, hung;
  logic [30:0] fail_testnum;
  logic [2:0] status;
  logic [31:0] cycle_count, retire_count;
  int n_cmp = 0;
  int n_bad = 0;

  riscv_test_monitor #(.HALT_PC(HALT), .TIMEOUT_CYCLES(TO), .HANG_LIMIT(HL), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc), .gp_value(gp_value),
    .done(done), .passed(passed), .failed(failed), .timed_out(timed_out), .hung(hung),
    .fail_testnum(fail_testnum), .status(status), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] flags();
    return {done, passed, failed, timed_out, hung, status};
  endfunction

  function automatic logic [7:0] expect_flags(int e);
    return {e != 0, e == 1, e == 2, e == 3, e == 4, 3'(e)};
  endfunction

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] gp);
    retire_valid = v;
    retire_pc = pc;
    gp_value = gp;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, '0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, HALT, 32'h1);
    rst = 1'b0;
    n_cmp++;
    if ({flags(), fail_testnum, cycle_count, retire_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got flags=%b tn=%0d cyc=%0d ret=%0d exp all zero", flags(), fail_testnum, cycle_count, retire_count);
    end
  endtask

  task automatic test_pass();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i * 4), 32'h1);
    n_cmp++;
    if (flags() !== 8'h00) begin n_bad++; $display("FAIL pass_before got %b exp 00000000", flags()); end
    step(1'b1, HALT, 32'h1);
    n_cmp++;
    if (flags() !== expect_flags(1)) begin n_bad++; $display("FAIL pass_flags got %b exp %b", flags(), expect_flags(1)); end
    n_cmp++;
    if ({retire_count, cycle_count, 1'b0, fail_testnum} !== {32'd11, 32'd11, 32'd0}) begin
      n_bad++; $display("FAIL pass_counts got ret=%0d cyc=%0d tn=%0d exp 11 11 0", retire_count, cycle_count, fail_testnum);
    end
  endtask

  task automatic test_fail();
    do_reset();
    step(1'b1, HALT, 32'h7);
    n_cmp++;
    if ({flags(), fail_testnum} !== {expect_flags(2), 31'd3}) begin
      n_bad++; $display("FAIL fail_flags got %b tn=%0d exp %b tn=3", flags(), fail_testnum, expect_flags(2));
    end
    for (int i = 0; i < 100; i++) step(1'b1, 32'($urandom_range(0, 31) * 4), $urandom);
    n_cmp++;
    if ({flags(), fail_testnum, cycle_count, retire_count} !== {expect_flags(2), 31'd3, 32'd1, 32'd1}) begin
      n_bad++; $display("FAIL fail_sticky got %b tn=%0d cyc=%0d ret=%0d exp %b 3 1 1", flags(), fail_testnum, cycle_count, retire_count, expect_flags(2));
    end
    do_reset();
    step(1'b0, HALT, 32'h1);
    step(1'b1, HALT, 32'h8);
    n_cmp++;
    if ({flags(), fail_testnum, cycle_count, retire_count} !== {expect_flags(2), 31'd0, 32'd2, 32'd1}) begin
      n_bad++; $display("FAIL fail_even got %b tn=%0d cyc=%0d ret=%0d exp %b 0 2 1", flags(), fail_testnum, cycle_count, retire_count, expect_flags(2));
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < TO - 1; i++) step(1'b1, 32'h200 + 32'(i * 4), 32'h1);
    n_cmp++;
    if ({flags(), cycle_count} !== {8'h00, 32'(TO - 1)}) begin
      n_bad++; $display("FAIL timeout_before got %b cyc=%0d exp 0 %0d", flags(), cycle_count, TO - 1);
    end
    step(1'b1, 32'h400, 32'h1);
    n_cmp++;
    if ({flags(), cycle_count, retire_count} !== {expect_flags(3), 32'(TO), 32'(TO)}) begin
      n_bad++; $display("FAIL timeout_flags got %b cyc=%0d ret=%0d exp %b %0d %0d", flags(), cycle_count, retire_count, expect_flags(3), TO, TO);
    end
    for (int i = 0; i < 5; i++) step(1'b1, HALT, 32'h1);
    n_cmp++;
    if ({flags(), cycle_count} !== {expect_flags(3), 32'(TO)}) begin
      n_bad++; $display("FAIL timeout_sticky got %b cyc=%0d exp %b %0d", flags(), cycle_count, expect_flags(3), TO);
    end
  endtask

  task automatic test_hang();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h100, 32'h0);
    n_cmp++;
    if (flags() !== 8'h00) begin n_bad++; $display("FAIL hang_early got %b exp 00000000", flags()); end
    step(1'b1, 32'h100, 32'h0);
    n_cmp++;
    if ({flags(), retire_count} !== {expect_flags(4), 32'd4}) begin
      n_bad++; $display("FAIL hang_flags got %b ret=%0d exp %b 4", flags(), retire_count, expect_flags(4));
    end
    do_reset();
    step(1'b1, 32'h100, 0); step(1'b1, 32'h100, 0); step(1'b1, 32'h104, 0); step(1'b1, 32'h100, 0);
    n_cmp++;
    if (flags() !== 8'h00) begin n_bad++; $display("FAIL hang_broken got %b exp 00000000", flags()); end
    do_reset();
    step(1'b1, 32'h100, 0); step(1'b0, 32'h104, 0); step(1'b1, 32'h100, 0);
    step(1'b0, 32'h108, 0); step(1'b1, 32'h100, 0); step(1'b1, 32'h100, 0);
    n_cmp++;
    if (flags() !== expect_flags(4)) begin n_bad++; $display("FAIL hang_idle_gaps got %b exp %b", flags(), expect_flags(4)); end
  endtask

  task automatic test_priority();
    do_reset();
    for (int i = 0; i < TO - 1; i++) step(1'b1, 32'h800 + 32'(i * 4), 32'h0);
    step(1'b1, HALT, 32'h1);
    n_cmp++;
    if ({flags(), cycle_count} !== {expect_flags(1), 32'(TO)}) begin
      n_bad++; $display("FAIL prio_halt_timeout got %b cyc=%0d exp %b %0d", flags(), cycle_count, expect_flags(1), TO);
    end
    do_reset();
    for (int i = 0; i < TO - 4; i++) step(1'b1, 32'h800 + 32'(i * 4), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h300, 32'h0);
    n_cmp++;
    if (flags() !== expect_flags(4)) begin n_bad++; $display("FAIL prio_hang_timeout got %b exp %b", flags(), expect_flags(4)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 32'h10, 0);
    step(1'b1, HALT, 32'h1);
    rst = 1'b1;
    step(1'b1, HALT, 32'h7);
    rst = 1'b0;
    n_cmp++;
    if ({flags(), fail_testnum, cycle_count, retire_count} !== '0) begin
      n_bad++; $display("FAIL reset_after_pass got %b tn=%0d cyc=%0d ret=%0d exp all zero", flags(), fail_testnum, cycle_count, retire_count);
    end
    step(1'b1, 32'h20, 0);
    step(1'b1, HALT, 32'h5);
    n_cmp++;
    if ({flags(), fail_testnum, cycle_count, retire_count} !== {expect_flags(2), 31'd2, 32'd2, 32'd2}) begin
      n_bad++; $display("FAIL rerun_fail got %b tn=%0d cyc=%0d ret=%0d exp %b 2 2 2", flags(), fail_testnum, cycle_count, retire_count, expect_flags(2));
    end
  endtask

  // Model: scan the whole pre-generated sequence for the first deciding cycle
  task automatic test_random();
    logic v[64];
    logic [31:0] pc[64], gp[64];
    for (int t = 0; t < 40; t++) begin
      int n, e, k_dec, rets, run;
      logic [31:0] prev, tn, gsel;
      n = $urandom_range(20, 60);
      for (int k = 0; k < n; k++) begin
        int r;
        v[k] = $urandom_range(0, 9) != 0;
        r = $urandom_range(0, 24);
        pc[k] = r == 0 ? HALT : r < 14 ? 32'h100 : 32'h100 + 32'($urandom_range(1, 3) * 4);
        r = $urandom_range(0, 2);
        gsel = $urandom;
        gp[k] = r == 0 ? 32'h1 : r == 1 ? (gsel | 32'h1) : (gsel & ~32'h1);
      end
      e = 0; k_dec = n; rets = 0; run = 0; prev = '0; tn = '0;
      for (int k = 0; k < n && e == 0; k++) begin
        if (v[k]) begin
          rets++;
          run = (run > 0 && pc[k] == prev) ? run + 1 : 1;
          prev = pc[k];
        end
        if (v[k] && pc[k] == HALT) begin
          e = gp[k] == 32'h1 ? 1 : 2;
          tn = (gp[k] != 32'h1 && gp[k][0]) ? gp[k] >> 1 : 32'h0;
        end else if (v[k] && run >= HL) e = 4;
        else if (k + 1 == TO) e = 3;
        if (e != 0) k_dec = k + 1;
      end
      do_reset();
      for (int k = 0; k < n; k++) step(v[k], pc[k], gp[k]);
      n_cmp++;
      if ({flags(), fail_testnum, cycle_count, retire_count} !== {expect_flags(e), tn[30:0], 32'(k_dec), 32'(rets)}) begin
        n_bad++;
        $display("FAIL random_%0d got %b tn=%0d cyc=%0d ret=%0d exp %b tn=%0d cyc=%0d ret=%0d",
                 t, flags(), fail_testnum, cycle_count, retire_count, expect_flags(e), tn, k_dec, rets);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_hang();
    test_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
